// File: rtl/memory_bus_controller.sv
// Two-phase sequencer and external memory bus master: fetches ahead of every
// phase 1, runs the phase-2 data access, and hides wait states as 00 cycles.
module memory_bus_controller #(
  parameter logic [31:0] RESET_INSTRUCTION = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  output logic [1:0]  phase,
  input  logic [31:0] fetch_address,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        pad_read,
  input  logic        pad_write,
  input  logic        input_buffer_write,
  input  logic [1:0]  pad_data_size,
  input  logic [2:0]  data_type,
  input  logic        input_buffer_read,
  output logic [31:0] instruction_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_fault,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned BEW = 4;

  typedef enum logic [1:0] {ST_FETCH, ST_PH1, ST_PH2, ST_MEM} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             bus_read_q, bus_read_d;
  logic             bus_write_q, bus_write_d;
  logic [DW-1:0]    bus_address_q, bus_address_d;
  logic [BEW-1:0]   bus_be_q, bus_be_d;
  logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
  logic [DW-1:0]    instr_q, instr_d;
  logic [DW-1:0]    load_buf_q, load_buf_d;
  logic             fault_q, fault_d;
  logic [2:0]       dtype_q, dtype_d;
  logic [1:0]       offset_q, offset_d;

  logic             req_store_c, req_load_c, misaligned_c;
  logic [BEW-1:0]   store_be_c;
  logic [DW-1:0]    store_data_c, lane_c, load_ext_c;
  logic             unused_fetch_lsbs_c;

  assign unused_fetch_lsbs_c = ^fetch_address[1:0];

  // Phase-2 request decode; a store takes priority over a simultaneous load.
  always_comb begin
    req_store_c  = pad_write;
    req_load_c   = pad_read & input_buffer_write & ~pad_write;
    misaligned_c = ((pad_data_size == 2'b01) & address[0]) |
                   (pad_data_size[1] & (address[1:0] != 2'b00));
    case (pad_data_size)
      2'b00: begin
        store_be_c   = BEW'(4'b0001 << address[1:0]);
        store_data_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        store_be_c   = BEW'(4'b0011 << address[1:0]);
        store_data_c = {2{write_data[15:0]}};
      end
      default: begin
        store_be_c   = 4'hF;
        store_data_c = write_data;
      end
    endcase
  end

  // Load lane select and extension by funct3.
  always_comb begin
    lane_c = bus_read_data >> {offset_q, 3'b000};
    case (dtype_q)
      3'd0:    load_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'd1:    load_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'd4:    load_ext_c = {24'd0, lane_c[7:0]};
      3'd5:    load_ext_c = {16'd0, lane_c[15:0]};
      default: load_ext_c = bus_read_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_address_d = bus_address_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    instr_d       = instr_q;
    load_buf_d    = load_buf_q;
    fault_d       = 1'b0;
    dtype_d       = dtype_q;
    offset_d      = offset_q;
    phase_d       = 2'b00;
    case (state_q)
      ST_FETCH: begin
        // Only after reset is FETCH occupied without a request in flight.
        if (!bus_read_q) begin
          bus_read_d    = 1'b1;
          bus_address_d = {fetch_address[31:2], 2'b00};
          bus_be_d      = 4'hF;
        end else if (bus_ready) begin
          instr_d    = bus_read_data;
          bus_read_d = 1'b0;
          state_d    = ST_PH1;
        end
      end
      ST_PH1: state_d = ST_PH2;
      ST_PH2: begin
        dtype_d  = data_type;
        offset_d = address[1:0];
        if ((req_store_c | req_load_c) & ~misaligned_c) begin
          state_d       = ST_MEM;
          bus_read_d    = req_load_c;
          bus_write_d   = req_store_c;
          bus_address_d = {address[31:2], 2'b00};
          bus_be_d      = req_store_c ? store_be_c : 4'hF;
          bus_wdata_d   = store_data_c;
        end else begin
          fault_d       = req_store_c | req_load_c;
          state_d       = ST_FETCH;
          bus_read_d    = 1'b1;
          bus_write_d   = 1'b0;
          bus_address_d = {fetch_address[31:2], 2'b00};
          bus_be_d      = 4'hF;
        end
      end
      ST_MEM: begin
        if (bus_ready) begin
          if (bus_read_q) load_buf_d = load_ext_c;
          state_d       = ST_FETCH;
          bus_read_d    = 1'b1;
          bus_write_d   = 1'b0;
          bus_address_d = {fetch_address[31:2], 2'b00};
          bus_be_d      = 4'hF;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (state_d == ST_PH1) phase_d = 2'b01;
    else if (state_d == ST_PH2) phase_d = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      phase_q       <= 2'b00;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_address_q <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      instr_q       <= RESET_INSTRUCTION;
      load_buf_q    <= '0;
      fault_q       <= 1'b0;
      dtype_q       <= '0;
      offset_q      <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_address_q <= bus_address_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      instr_q       <= instr_d;
      load_buf_q    <= load_buf_d;
      fault_q       <= fault_d;
      dtype_q       <= dtype_d;
      offset_q      <= offset_d;
    end
  end

  assign phase            = phase_q;
  assign bus_read         = bus_read_q;
  assign bus_write        = bus_write_q;
  assign bus_address      = bus_address_q;
  assign bus_byte_enable  = bus_be_q;
  assign bus_write_data   = bus_wdata_q;
  assign instruction_out  = instr_q;
  assign misaligned_fault = fault_q;
  assign load_data_out    = input_buffer_read ? load_buf_q : '0;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed plus randomized bench for memory_bus_controller, acting as bus slave
// and checking against an arithmetic model of fetch, store lanes and load extension.
module tb_memory_bus_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  phase;
  logic [31:0] fetch_address, address, write_data;
  logic        pad_read, pad_write, input_buffer_write, input_buffer_read;
  logic [1:0]  pad_data_size;
  logic [2:0]  data_type;
  logic [31:0] instruction_out, load_data_out;
  logic        misaligned_fault;
  logic [31:0] bus_address;
  logic        bus_read, bus_write;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data, bus_read_data;
  logic        bus_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_buf = 32'd0;
  logic [31:0] cur_fa, cur_instr;

  always #5 clock = ~clock;

  memory_bus_controller dut (
    .clock(clock), .reset(reset), .phase(phase),
    .fetch_address(fetch_address), .address(address), .write_data(write_data),
    .pad_read(pad_read), .pad_write(pad_write), .input_buffer_write(input_buffer_write),
    .pad_data_size(pad_data_size), .data_type(data_type),
    .input_buffer_read(input_buffer_read), .instruction_out(instruction_out),
    .load_data_out(load_data_out), .misaligned_fault(misaligned_fault),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] dt);
    logic [31:0] sh, b, h;
    sh = w / (32'd1 << (8 * int'(off)));
    b  = sh % 256;
    h  = sh % 65536;
    case (dt)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 32'(2 ** int'(off)) & 32'hF;
    if (sz == 2'd1) return 32'(3 * (2 ** int'(off))) & 32'hF;
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd1) return (int'(off) % 2) != 0;
    if (sz >= 2'd2) return off != 2'd0;
    return 1'b0;
  endfunction

  // One instruction: fetch (wf waits), PH1, PH2 request, optional MEM (wm waits).
  task automatic do_instr(input int wf, input logic [31:0] instr, input logic ibr,
                          input logic pw, input logic pr, input logic ibw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [2:0] dt,
                          input logic [31:0] mword, input int wm,
                          input logic [31:0] nfa, input logic abort);
    logic rs, rl, mis;
    logic [31:0] a_snap, d_snap, be_snap;
    chk("fetch_read", 32'(bus_read), 32'd1);
    chk("fetch_write", 32'(bus_write), 32'd0);
    chk("fetch_addr", bus_address, cur_fa & ~32'd3);
    chk("fetch_be", 32'(bus_byte_enable), 32'hF);
    for (int w = 0; w < wf; w++) begin
      bus_ready = 1'b0;
      tick();
      chk("fetch_wait_phase", 32'(phase), 32'd0);
      chk("fetch_wait_read", 32'(bus_read), 32'd1);
      chk("fetch_wait_addr", bus_address, cur_fa & ~32'd3);
      chk("fetch_wait_be", 32'(bus_byte_enable), 32'hF);
      chk("instr_hold", instruction_out, cur_instr);
    end
    bus_ready = 1'b1;
    bus_read_data = instr;
    input_buffer_read = ibr;
    tick();
    cur_instr = instr;
    chk("ph1_phase", 32'(phase), 32'd1);
    chk("ph1_instr", instruction_out, instr);
    chk("ph1_read", 32'(bus_read), 32'd0);
    chk("ph1_fault", 32'(misaligned_fault), 32'd0);
    chk("ph1_load_data", load_data_out, ibr ? exp_buf : 32'd0);
    bus_ready = 1'($urandom_range(0, 1));
    input_buffer_read = 1'b0;
    pad_write = pw; pad_read = pr; input_buffer_write = ibw;
    address = addr; write_data = wd; pad_data_size = sz; data_type = dt;
    tick();
    chk("ph2_phase", 32'(phase), 32'd2);
    chk("ph2_bus_idle", {30'd0, bus_read, bus_write}, 32'd0);
    chk("ph2_load_data_off", load_data_out, 32'd0);
    fetch_address = nfa;
    tick();
    pad_write = 1'b0; pad_read = 1'b0; input_buffer_write = 1'b0;
    rs  = pw;
    rl  = !pw && pr && ibw;
    mis = (rs || rl) && m_mis(sz, addr[1:0]);
    chk("fault", 32'(misaligned_fault), 32'(mis));
    if (!(rs || rl) || mis) begin
      chk("nomem_phase", 32'(phase), 32'd0);
      chk("nomem_write", 32'(bus_write), 32'd0);
      cur_fa = nfa;
      return;
    end
    chk("mem_phase", 32'(phase), 32'd0);
    chk("mem_read", 32'(bus_read), 32'(rl));
    chk("mem_write", 32'(bus_write), 32'(rs));
    chk("mem_addr", bus_address, addr & ~32'd3);
    chk("mem_be", 32'(bus_byte_enable), rl ? 32'hF : m_be(sz, addr[1:0]));
    if (rs) chk("mem_wdata", bus_write_data, m_wd(sz, wd));
    if (abort) begin
      bus_ready = 1'b0;
      reset = 1'b1;
      tick();
      chk("abort_read", 32'(bus_read), 32'd0);
      chk("abort_write", 32'(bus_write), 32'd0);
      chk("abort_phase", 32'(phase), 32'd0);
      tick();
      reset = 1'b0;
      bus_ready = 1'b1;
      tick();
      exp_buf = 32'd0;
      cur_fa = nfa;
      cur_instr = 32'h00000013;
      chk("abort_instr_reset", instruction_out, cur_instr);
      return;
    end
    a_snap = bus_address;
    d_snap = bus_write_data;
    be_snap = 32'(bus_byte_enable);
    for (int w = 0; w < wm; w++) begin
      bus_ready = 1'b0;
      tick();
      chk("mem_wait_phase", 32'(phase), 32'd0);
      chk("mem_wait_req", {30'd0, bus_read, bus_write}, {30'd0, rl, rs});
      chk("mem_wait_addr", bus_address, a_snap);
      chk("mem_wait_be", 32'(bus_byte_enable), be_snap);
      chk("mem_wait_wdata", bus_write_data, d_snap);
    end
    bus_ready = 1'b1;
    bus_read_data = mword;
    tick();
    if (rl) exp_buf = m_load(mword, addr[1:0], dt);
    chk("post_mem_write", 32'(bus_write), 32'd0);
    chk("post_mem_phase", 32'(phase), 32'd0);
    cur_fa = nfa;
  endtask

  initial begin
    logic [2:0] dts [8];
    dts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b1;
    fetch_address = 32'h100; address = '0; write_data = '0;
    pad_read = 1'b0; pad_write = 1'b0; input_buffer_write = 1'b0;
    pad_data_size = 2'd0; data_type = 3'd0; input_buffer_read = 1'b0;
    bus_ready = 1'b1; bus_read_data = 32'h00500093;
    tick();
    tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_bus_req", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_addr", bus_address, 32'd0);
    chk("rst_be", 32'(bus_byte_enable), 32'd0);
    chk("rst_wdata", bus_write_data, 32'd0);
    chk("rst_instr", instruction_out, 32'h00000013);
    chk("rst_fault", 32'(misaligned_fault), 32'd0);
    reset = 1'b0;
    tick();
    chk("pre_fetch_instr", instruction_out, 32'h00000013);
    chk("pre_fetch_phase", 32'(phase), 32'd0);
    cur_fa = 32'h100;
    cur_instr = 32'h00000013;

    do_instr(0, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0);
    do_instr(3, 32'h00B001A3, 0, 1, 0, 0, 32'h203, 32'hAB, 2'd0, 3'd0, 0, 1, 32'h108, 0);
    do_instr(1, 32'h11111111, 0, 0, 1, 1, 32'h302, 0, 2'd0, 3'd0, 32'h80FF7F01, 2, 32'h10C, 0);
    do_instr(0, 32'h22222222, 1, 0, 1, 1, 32'h303, 0, 2'd0, 3'd4, 32'h80FF7F01, 0, 32'h110, 0);
    do_instr(0, 32'h33333333, 1, 0, 1, 1, 32'h302, 0, 2'd1, 3'd1, 32'h80FF7F01, 1, 32'h114, 0);
    do_instr(2, 32'h44444444, 1, 0, 1, 1, 32'h300, 0, 2'd3, 3'd2, 32'h80FF7F01, 0, 32'h118, 0);
    chk("lw_value", exp_buf, 32'h80FF7F01);
    do_instr(0, 32'h55555555, 1, 0, 1, 1, 32'h202, 0, 2'd3, 3'd2, 0, 0, 32'h11C, 0);
    do_instr(0, 32'h66666666, 0, 1, 1, 1, 32'h402, 32'h1234ABCD, 2'd1, 3'd0, 0, 0, 32'h120, 0);
    do_instr(0, 32'h77777777, 0, 0, 1, 1, 32'h400, 0, 2'd3, 3'd2, 32'hDEADBEEF, 0, 32'h200, 1);
    do_instr(1, 32'h88888888, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 0);

    for (int i = 0; i < 60; i++) begin
      do_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 2'($urandom_range(0, 3)), dts[$urandom_range(0, 7)],
               $urandom, int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
